// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier: one multiplier bit per clock,
// signed/unsigned at run time. Optional macro SEQ_MULT_EARLY_TERM_EN ends CALC early.
module seq_mult_param #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t          r_state;
  logic [2*N-1:0]  r_mcand;
  logic [N:0]      r_mplier;
  logic [2*N-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [2*N-1:0]  r_prod;
  logic            r_done;

  logic [N:0]      w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic            w_a_neg, w_b_neg;
  logic [N:0]      w_mplier_nxt;
  logic            w_last;
  logic [2*N-1:0]  w_prod;

  // Magnitudes are N+1 bits wide so that -2^(N-1) is represented exactly.
  assign w_a_neg = signed_mode & a_in[N-1];
  assign w_b_neg = signed_mode & b_in[N-1];
  assign w_a_ext = {w_a_neg, a_in};
  assign w_b_ext = {w_b_neg, b_in};
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_mplier_nxt = r_mplier >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_last = (w_mplier_nxt == '0) || (r_cnt == CW'(N-1));
`else
  assign w_last = (r_cnt == CW'(N-1));
`endif

  // Negating a zero magnitude yields zero, so no negative-zero can appear.
  assign w_prod = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{(N-1){1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIN;
        end
        S_FIN: begin
          r_prod  <= w_prod;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign product = r_prod;

endmodule
